// File: rtl/input_buffer_fifo.sv
// input_buffer_fifo: first-word-fall-through buffer between the trace source
// and the filter/reduce pipeline. The trace source cannot be stalled, so a
// vector arriving while the FIFO is full is dropped and counted; any eof it
// carried is folded into the next stored vector so frame boundaries survive
// (adjacent frames merge instead).
//
// Handshake: downstream side is strict valid/ready. valid_out means the head
// entry is presented on vector_out/eof_out; the entry is consumed on a rising
// edge where valid_out && ready_in. While valid_out && !ready_in the head holds
// steady. ready_in while empty does nothing. The upstream side has valid only:
// valid_in marks a vector every cycle it is high and eof_in is ignored without it.
module input_buffer_fifo #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IB_DEPTH   = 4,
  localparam int CW        = $clog2(IB_DEPTH + 1)
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           valid_in,
  input  logic                           eof_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
  input  logic                           ready_in,
  output logic                           valid_out,
  output logic                           eof_out,
  output logic [N-1:0][DATA_WIDTH-1:0]   vector_out,
  output logic [CW-1:0]                  occupancy_out,
  output logic                           full_out,
  output logic                           overflow_out,
  output logic [15:0]                    drop_count_out
);

  localparam int PW = (IB_DEPTH > 1) ? $clog2(IB_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(IB_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(IB_DEPTH);

  logic [N-1:0][DATA_WIDTH-1:0] mem_vec [IB_DEPTH];
  logic [IB_DEPTH-1:0]          mem_eof;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          eof_pending;
  logic          overflow;
  logic [15:0]   drop_count;

  logic rd_ev;
  logic wr_ev;
  logic drop_ev;

  // A full FIFO still accepts a write in a cycle where its head is consumed.
  assign rd_ev   = (cnt != '0) && ready_in;
  assign wr_ev   = valid_in && ((cnt < FULL_CNT) || rd_ev);
  assign drop_ev = valid_in && !wr_ev;

  // Storage array: no reset needed, every read is gated by cnt.
  always_ff @(posedge clk_in) begin
    if (wr_ev) begin
      mem_vec[wr_ptr] <= vector_in;
      mem_eof[wr_ptr] <= eof_in | eof_pending;
    end
  end

  // Pointers, occupancy, and the drop/overflow bookkeeping.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      eof_pending <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (wr_ev) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_ev) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_ev, rd_ev})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Write and drop are mutually exclusive, so set and clear never collide.
      if (wr_ev) begin
        eof_pending <= 1'b0;
      end else if (drop_ev && eof_in) begin
        eof_pending <= 1'b1;
      end
      if (drop_ev) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    valid_out  = (cnt != '0);
    eof_out    = 1'b0;
    vector_out = '0;
    if (valid_out) begin
      eof_out    = mem_eof[rd_ptr];
      vector_out = mem_vec[rd_ptr];
    end
  end

  assign occupancy_out  = cnt;
  assign full_out       = (cnt == FULL_CNT);
  assign overflow_out   = overflow;
  assign drop_count_out = drop_count;

endmodule
